switch_debounce_io: RTL and testbench
=====================================

// Module: switch_debounce_io
// PURPOSE
//  Input stage directly upstream of the memory-mapped I/O block. Synchronises
//  and debounces raw board switches, then supplies the clean value that the
//  I/O block returns for a read of switch address 9'h140. Also exposes a
//  memory-mapped sticky "switches changed" status bit at STATUS_ADDR, so
//  software can poll for new input. Reading the status bit clears it.
// PARAMETERS
//  N           8       number of switch bits debounced
//  DB_CYCLES   50000   consecutive stable cycles needed to accept a change (>=2)
//  CNT_W       16      per-bit counter width; 2**CNT_W must exceed DB_CYCLES
//  STATUS_ADDR 9'h141  mem_addr that reads/clears the sticky change flag
// PORTS
//  clk        in   1   system clock; all state updates on rising edge
//  reset_n    in   1   synchronous, active-low reset
//  SW_raw     in   N   asynchronous switch pins
//  mem_addr   in   9   CPU memory address
//  mem_cmd    in   2   2'b10 read, 2'b01 write, 2'b00 none
//  SW_clean   out  N   debounced switch value, registered
//  sw_changed out  1   one-cycle pulse when any SW_clean bit changes
//  read_data  out  16  status read data; high-Z when not selected
// BEHAVIOUR
//  Reset (reset_n==0 at an edge): sync FFs, SW_clean, all counters,
//   sw_changed and the sticky flag all go to 0. Reset mid-count abandons the count.
//  Sync: two FFs per bit, s1<=SW_raw, s2<=s1. Only s2 is used downstream.
//  Per bit i, at each edge:
//   - s2[i]==SW_clean[i]: cnt[i]<=0.
//   - s2[i]!=SW_clean[i] and cnt[i]==DB_CYCLES-1: SW_clean[i]<=s2[i], cnt[i]<=0.
//   - otherwise: cnt[i]<=cnt[i]+1.
//   A bounce back to the accepted value before acceptance zeroes the count,
//   so no change is accepted.
//  Latency: SW_raw is sampled at edge k and then held. SW_clean updates at
//   edge k+1+DB_CYCLES.
//  Bits are independent. Several bits may update at the same edge.
//  sw_changed: registered. It is 1 for exactly the cycle after any update
//   edge, i.e. the first cycle SW_clean shows the new value. Otherwise 0.
//  Sticky flag: set at any update edge. Cleared at an edge where
//   mem_cmd==2'b10 and mem_addr==STATUS_ADDR. If set and clear occur on the
//   same edge, set wins (flag stays 1).
//  read_data is combinational:
//   - {15'b0,sticky} when mem_cmd==2'b10 and mem_addr==STATUS_ADDR.
//   - 16'bz otherwise, so it can share the read bus with other slaves.
//  Writes to STATUS_ADDR are ignored. No other address is decoded here.
// TESTING (bench uses DB_CYCLES=4)
//  1. Hold reset_n=0 for 3 edges with SW_raw=8'hFF
//     -> SW_clean=0, sw_changed=0, read of 9'h141 returns 16'h0000.
//  2. Step SW_raw 8'h00->8'h05, sampled at edge k
//     -> SW_clean=8'h05 after edge k+5; sw_changed high 1 cycle; sticky=1.
//  3. Toggle SW_raw[0] for 3 cycles, then return it
//     -> SW_clean unchanged; sw_changed never asserts.
//  4. Read 9'h141 (mem_cmd=2'b10) after test 2
//     -> read_data=16'h0001; the next read returns 16'h0000.
//  5. Status read on the same edge as a new accept
//     -> read_data=16'h0001; sticky remains 1 afterwards.
//  6. Assert reset_n=0 mid-count (cnt=2)
//     -> counts cleared; SW_clean=0; read_data=16'bz when mem_addr!=9'h141.

Source files
------------

// File: rtl/switch_debounce_io_if.sv
// Memory-bus view of the switch input stage.
//   mem_addr  : 9-bit CPU address, driven by the bus master
//   mem_cmd   : 2'b10 read, 2'b01 write, 2'b00 none, driven by the bus master
//   read_data : 16-bit shared read bus; a slave drives it only when selected
interface switch_debounce_io_if;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_cmd;
  wire  [15:0] read_data;

  modport master (
    output mem_addr,
    output mem_cmd,
    input  read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_cmd,
    output read_data
  );
endinterface

// File: rtl/switch_debounce_io.sv
// Switch input stage in front of the memory-mapped I/O block.
// Synchronises and debounces raw board switches and keeps a sticky "switches
// changed" flag that software reads (and thereby clears) at STATUS_ADDR.
//   clk        : system clock, all state on the rising edge
//   reset_n    : synchronous active-low reset
//   SW_raw     : asynchronous switch pins
//   SW_clean   : debounced switch value (registered)
//   sw_changed : one-cycle pulse, high the first cycle SW_clean shows a new value
//   bus        : memory bus slave; read_data is {15'b0, sticky} on a status read,
//                high-Z otherwise so other slaves can share the read bus
module switch_debounce_io #(
  parameter int unsigned N           = 8,
  parameter int unsigned DB_CYCLES   = 50000,
  parameter int unsigned CNT_W       = 16,
  parameter logic [8:0]  STATUS_ADDR = 9'h141
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         SW_raw,
  output logic [N-1:0]         SW_clean,
  output logic                 sw_changed,
  switch_debounce_io_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);
  localparam logic [1:0]       CmdRead = 2'b10;

  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [CNT_W-1:0] cnt_q [N];
  logic             sticky_q;
  logic [N-1:0]     differ;
  logic [N-1:0]     accept;
  logic             status_sel;

  assign status_sel = (bus.mem_cmd == CmdRead) && (bus.mem_addr == STATUS_ADDR);

  // A bit is accepted once its synchronised value has disagreed with the
  // clean value for DB_CYCLES consecutive edges (counter sits at DB_CYCLES-1).
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < N; i++) begin
      differ[i] = sync2_q[i] != SW_clean[i];
      accept[i] = differ[i] && (cnt_q[i] == CntLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      SW_clean   <= '0;
      sw_changed <= 1'b0;
      sticky_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= SW_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < N; i++) begin
        if (!differ[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          SW_clean[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      sw_changed <= |accept;
      // A new accept on the same edge as a status read keeps the flag set so
      // software cannot miss that change.
      if (|accept) begin
        sticky_q <= 1'b1;
      end else if (status_sel) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign bus.read_data = status_sel ? {15'b0, sticky_q} : 16'bz;

endmodule

// File: tb/tb_switch_debounce_io.sv
module tb_switch_debounce_io;

  localparam int unsigned DB = 4;

  typedef struct packed {
    logic [7:0] clean;
    logic       changed;
    logic       sticky;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] SW_raw = 8'h00;
  logic [7:0] SW_clean;
  logic       sw_changed;

  switch_debounce_io_if bus ();

  switch_debounce_io #(
    .N           (8),
    .DB_CYCLES   (DB),
    .CNT_W       (16),
    .STATUS_ADDR (9'h141)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .SW_raw     (SW_raw),
    .SW_clean   (SW_clean),
    .sw_changed (sw_changed),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  exp_t exp_q[$];

  // Reference model: a switch bit is accepted when the last DB synchronised
  // samples all disagree with the accepted value. Synchronised sample at an
  // edge is the raw value present two edges earlier (zero just after reset).
  logic [7:0] samp_q[$];
  logic [7:0] s2_hist[$];
  logic [7:0] m_clean;
  logic       m_changed;
  logic       m_sticky;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    logic [7:0] s2;
    logic [7:0] flips;
    logic       all_differ;
    if (!reset_n) begin
      m_clean   = 8'h00;
      m_changed = 1'b0;
      m_sticky  = 1'b0;
      samp_q    = {8'h00, 8'h00};
      s2_hist   = {};
      m_valid   = 1'b1;
    end else if (m_valid) begin
      s2 = samp_q.pop_front();
      samp_q.push_back(SW_raw);
      s2_hist.push_back(s2);
      if (s2_hist.size() > DB) void'(s2_hist.pop_front());
      flips = 8'h00;
      if (s2_hist.size() == DB) begin
        for (int i = 0; i < 8; i++) begin
          all_differ = 1'b1;
          for (int k = 0; k < DB; k++) begin
            if (s2_hist[k][i] == m_clean[i]) all_differ = 1'b0;
          end
          flips[i] = all_differ;
        end
      end
      m_clean   = m_clean ^ flips;
      m_changed = (flips != 8'h00);
      if (flips != 8'h00) m_sticky = 1'b1;
      else if (bus.mem_cmd == 2'b10 && bus.mem_addr == 9'h141) m_sticky = 1'b0;
    end
    if (m_valid) exp_q.push_back('{clean: m_clean, changed: m_changed, sticky: m_sticky});
  end

  // Monitor: mid-cycle, after the driver has settled this cycle's inputs.
  always begin
    exp_t e;
    logic sel;
    logic [15:0] rd;
    @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      sel = (bus.mem_cmd == 2'b10) && (bus.mem_addr == 9'h141);
      rd  = bus.read_data;
      vectors++;
      if (SW_clean !== e.clean) begin
        miscompares++;
        $display("FAIL sw_clean t=%0t got=%h want=%h", $time, SW_clean, e.clean);
      end
      vectors++;
      if (sw_changed !== e.changed) begin
        miscompares++;
        $display("FAIL sw_changed t=%0t got=%b want=%b", $time, sw_changed, e.changed);
      end
      vectors++;
      if (sel) begin
        if (rd !== {15'b0, e.sticky}) begin
          miscompares++;
          $display("FAIL read_status t=%0t got=%h want=%h", $time, rd, {15'b0, e.sticky});
        end
      end else begin
        // A 2-state simulator resolves an undriven bus to zero.
        if (!((rd === 16'bz) || (rd === 16'h0000))) begin
          miscompares++;
          $display("FAIL read_hiz t=%0t got=%h want=zzzz", $time, rd);
        end
      end
    end
  end

  task automatic drive(input logic rn, input logic [7:0] raw,
                       input logic [1:0] cmd, input logic [8:0] addr);
    @(negedge clk);
    reset_n      = rn;
    SW_raw       = raw;
    bus.mem_cmd  = cmd;
    bus.mem_addr = addr;
  endtask

  task automatic idle(input logic [7:0] raw, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, raw, 2'b00, 9'h000);
  endtask

  initial begin
    logic [7:0] raw;
    logic [1:0] cmd;
    logic [8:0] addr;
    int         r;
    bus.mem_cmd  = 2'b00;
    bus.mem_addr = 9'h000;

    // Reset with all switches high; status read during reset returns zero.
    drive(1'b0, 8'hFF, 2'b00, 9'h000);
    drive(1'b0, 8'hFF, 2'b00, 9'h000);
    drive(1'b0, 8'hFF, 2'b10, 9'h141);
    drive(1'b1, 8'h00, 2'b00, 9'h000);
    idle(8'h00, 6);

    // Clean step to 8'h05.
    idle(8'h05, 10);

    // Bounce bit 0 shorter than the debounce window, then return.
    idle(8'h04, 1);
    idle(8'h05, 1);
    idle(8'h04, 1);
    idle(8'h05, 8);

    // Status read returns 1, the following read returns 0.
    drive(1'b1, 8'h05, 2'b10, 9'h141);
    drive(1'b1, 8'h05, 2'b10, 9'h141);
    drive(1'b1, 8'h05, 2'b01, 9'h141);
    idle(8'h05, 2);

    // Continuous status reads spanning a new accept edge: set wins.
    for (int i = 0; i < DB + 3; i++) drive(1'b1, 8'h0F, 2'b10, 9'h141);
    idle(8'h0F, 3);
    drive(1'b1, 8'h0F, 2'b10, 9'h141);
    idle(8'h0F, 2);

    // Reset mid-count; other address must leave the bus undriven.
    idle(8'hF0, 4);
    drive(1'b0, 8'hF0, 2'b10, 9'h140);
    drive(1'b1, 8'hF0, 2'b10, 9'h140);
    idle(8'hF0, 12);

    // Randomised: mostly-held switches with occasional bursts of bouncing.
    raw = 8'hA5;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) raw = 8'($urandom);
      else if (r < 3) raw = raw ^ (8'h1 << $urandom_range(0, 7));
      cmd = 2'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    addr = 9'h141;
        2:       addr = 9'h140;
        default: addr = 9'($urandom);
      endcase
      drive(($urandom_range(0, 299) != 0), raw, cmd, addr);
    end
    idle(raw, 4);

    @(negedge clk);
    #5;
    vectors++;
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending want<=1", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
